// File: rtl/pool_rules_engine.sv
// Pool game rules engine. Tracks turns, shots and per-player pots, and makes the
// foul, re-spot and win/loss decisions. Every flag output decodes registered state only.
module pool_rules_engine #(
  parameter  int NUM_BALLS   = 3,
  parameter  int NUM_PLAYERS = 2,
  parameter  int SHOT_W      = 8,
  parameter  int MAX_SHOTS   = 0,
  localparam int PW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int CNT_W       = $clog2(NUM_BALLS + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         new_game,
  input  logic                         shot_made,
  input  logic                         all_balls_stopped,
  input  logic                         white_in_hole,
  input  logic [NUM_BALLS-1:0]         ball_in_hole,
  output logic                         cue_enable,
  output logic                         reset_cue,
  output logic                         reset_white_ball,
  output logic                         foul,
  output logic                         game_over,
  output logic                         game_win,
  output logic [PW-1:0]                current_player,
  output logic [PW-1:0]                winner,
  output logic [NUM_BALLS-1:0]         scored_mask,
  output logic [SHOT_W-1:0]            shots_counter,
  output logic [NUM_PLAYERS*CNT_W-1:0] player_pots
);

  typedef enum logic [2:0] {
    S_IDLE, S_AIM, S_MOVING, S_RESOLVE, S_WHITE_IN, S_LOSE, S_WIN
  } state_e;

  localparam int                FINAL       = NUM_BALLS - 1;
  localparam logic [PW-1:0]     LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [SHOT_W-1:0] SHOT_LIMIT  = SHOT_W'(MAX_SHOTS);

  state_e                              state_q, state_d;
  logic [PW-1:0]                       player_q, player_d;
  logic [PW-1:0]                       winner_q, winner_d;
  logic [NUM_BALLS-1:0]                mask_q, mask_d;
  logic [SHOT_W-1:0]                   shots_q, shots_d;
  logic [NUM_PLAYERS-1:0][CNT_W-1:0]   pots_q, pots_d;
  logic                                pot_shot_q, pot_shot_d;
  logic                                white_shot_q, white_shot_d;

  logic [NUM_BALLS-1:0] new_pots;
  logic [CNT_W-1:0]     new_cnt;
  logic [PW-1:0]        next_player;
  logic [PW-1:0]        leader;
  logic [CNT_W-1:0]     leader_cnt;
  logic                 lower_clear;

  // Only balls not already in the mask earn credit for the shooter.
  assign new_pots    = ball_in_hole & ~mask_q;
  assign next_player = (player_q == LAST_PLAYER) ? '0 : player_q + 1'b1;
  assign lower_clear = &mask_q[FINAL-1:0];

  always_comb begin
    new_cnt = '0;
    for (int i = 0; i < NUM_BALLS; i++) new_cnt = new_cnt + CNT_W'(new_pots[i]);
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    leader     = '0;
    leader_cnt = pots_q[0];
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (pots_q[p] > leader_cnt) begin
        leader     = PW'(p);
        leader_cnt = pots_q[p];
      end
    end
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    player_d     = player_q;
    winner_d     = winner_q;
    mask_d       = mask_q | ball_in_hole;
    shots_d      = shots_q;
    pots_d       = pots_q;
    pot_shot_d   = pot_shot_q;
    white_shot_d = white_shot_q;

    case (state_q)
      S_IDLE: state_d = S_AIM;
      S_AIM: begin
        if (shot_made) begin
          shots_d      = (shots_q != '1) ? shots_q + 1'b1 : shots_q;
          pot_shot_d   = 1'b0;
          white_shot_d = 1'b0;
          state_d      = S_MOVING;
        end
      end
      S_MOVING: begin
        if (|new_pots)     pot_shot_d   = 1'b1;
        if (white_in_hole) white_shot_d = 1'b1;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (PW'(p) == player_q) pots_d[p] = pots_q[p] + new_cnt;
        end
        if (all_balls_stopped) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (mask_q[FINAL]) begin
          if (white_shot_q || !lower_clear) begin
            state_d  = S_LOSE;
            winner_d = next_player;
          end else begin
            state_d  = S_WIN;
            winner_d = player_q;
          end
        end else if (white_shot_q) begin
          player_d = next_player;
          state_d  = S_WHITE_IN;
        end else if ((MAX_SHOTS != 0) && (shots_q == SHOT_LIMIT)) begin
          state_d  = S_LOSE;
          winner_d = leader;
        end else if (pot_shot_q) begin
          state_d  = S_AIM;
        end else begin
          player_d = next_player;
          state_d  = S_AIM;
        end
      end
      S_WHITE_IN: state_d = S_AIM;
      default:    state_d = state_q;
    endcase

    if (new_game) begin
      state_d      = S_IDLE;
      player_d     = '0;
      winner_d     = '0;
      mask_d       = '0;
      shots_d      = '0;
      pots_d       = '0;
      pot_shot_d   = 1'b0;
      white_shot_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      player_q     <= '0;
      winner_q     <= '0;
      mask_q       <= '0;
      shots_q      <= '0;
      pots_q       <= '0;
      pot_shot_q   <= 1'b0;
      white_shot_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      player_q     <= player_d;
      winner_q     <= winner_d;
      mask_q       <= mask_d;
      shots_q      <= shots_d;
      pots_q       <= pots_d;
      pot_shot_q   <= pot_shot_d;
      white_shot_q <= white_shot_d;
    end
  end

  always_comb begin
    cue_enable       = 1'b0;
    reset_cue        = 1'b0;
    reset_white_ball = 1'b0;
    foul             = 1'b0;
    game_over        = 1'b0;
    game_win         = 1'b0;
    case (state_q)
      S_IDLE: begin
        reset_cue        = 1'b1;
        reset_white_ball = 1'b1;
      end
      S_AIM:     cue_enable = 1'b1;
      S_RESOLVE: begin
        reset_cue = 1'b1;
        foul      = white_shot_q && !mask_q[FINAL];
      end
      S_WHITE_IN: begin
        reset_cue        = 1'b1;
        reset_white_ball = 1'b1;
      end
      S_LOSE:  game_over = 1'b1;
      S_WIN:   game_win  = 1'b1;
      default: cue_enable = 1'b0;
    endcase
  end

  assign current_player = player_q;
  assign winner         = winner_q;
  assign scored_mask    = mask_q;
  assign shots_counter  = shots_q;
  assign player_pots    = pots_q;

endmodule

// File: tb/tb_pool_rules_engine.sv
// Bench for pool_rules_engine: two instances (unlimited shots, limit of 2) driven shot by
// shot and compared against a game-level model of the pool rules.
module tb_pool_rules_engine;

  localparam int O_KEEP = 0, O_NEXT = 1, O_FOUL = 2, O_LOSE = 3, O_WIN = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       new_game[2], shot_made[2], stopped[2], white[2];
  logic [2:0] balls[2];
  logic       cue_en[2], rcue[2], rwhite[2], foul[2], over[2], win[2];
  logic       cur[2], winner[2];
  logic [2:0] mask[2];
  logic [7:0] shots[2];
  logic [3:0] pots[2];

  pool_rules_engine #(.NUM_BALLS(3), .NUM_PLAYERS(2), .SHOT_W(8), .MAX_SHOTS(0)) u_unl (
    .clk(clk), .reset(reset), .new_game(new_game[0]), .shot_made(shot_made[0]),
    .all_balls_stopped(stopped[0]), .white_in_hole(white[0]), .ball_in_hole(balls[0]),
    .cue_enable(cue_en[0]), .reset_cue(rcue[0]), .reset_white_ball(rwhite[0]),
    .foul(foul[0]), .game_over(over[0]), .game_win(win[0]), .current_player(cur[0]),
    .winner(winner[0]), .scored_mask(mask[0]), .shots_counter(shots[0]),
    .player_pots(pots[0])
  );

  pool_rules_engine #(.NUM_BALLS(3), .NUM_PLAYERS(2), .SHOT_W(8), .MAX_SHOTS(2)) u_lim (
    .clk(clk), .reset(reset), .new_game(new_game[1]), .shot_made(shot_made[1]),
    .all_balls_stopped(stopped[1]), .white_in_hole(white[1]), .ball_in_hole(balls[1]),
    .cue_enable(cue_en[1]), .reset_cue(rcue[1]), .reset_white_ball(rwhite[1]),
    .foul(foul[1]), .game_over(over[1]), .game_win(win[1]), .current_player(cur[1]),
    .winner(winner[1]), .scored_mask(mask[1]), .shots_counter(shots[1]),
    .player_pots(pots[1])
  );

  // Game-level model, one per instance.
  int         m_max[2];
  logic [2:0] m_mask[2];
  int         m_shots[2];
  int         m_pots[2][2];
  int         m_player[2];
  bit         m_done[2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear(int d);
    m_mask[d]    = '0;
    m_shots[d]   = 0;
    m_pots[d][0] = 0;
    m_pots[d][1] = 0;
    m_player[d]  = 0;
    m_done[d]    = 1'b0;
  endtask

  function automatic logic [3:0] exp_pots(int d);
    logic [1:0] p0, p1;
    p0 = 2'(m_pots[d][0]);
    p1 = 2'(m_pots[d][1]);
    return {p1, p0};
  endfunction

  task automatic check_counters(int d);
    check("shots", shots[d], m_shots[d]);
    check("mask", mask[d], m_mask[d]);
    check("pots", pots[d], exp_pots(d));
  endtask

  // Called just after a negedge; a ball pulse alongside new_game must not survive.
  task automatic start_game(int d);
    new_game[d] = 1'b1;
    balls[d]    = 3'($urandom_range(0, 7));
    @(negedge clk);
    new_game[d] = 1'b0;
    balls[d]    = '0;
    model_clear(d);
    check("idle_rcue", rcue[d], 1);
    check("idle_rwhite", rwhite[d], 1);
    check("idle_cue", cue_en[d], 0);
    check("idle_over", over[d], 0);
    check("idle_win", win[d], 0);
    check_counters(d);
    @(negedge clk);
    check("start_cue", cue_en[d], 1);
    check("start_player", cur[d], 0);
  endtask

  // One shot: pre is pocketed in the AIM cycle, then ncyc MOVING cycles, the last with stop.
  task automatic do_shot(int d, int ncyc, logic [2:0] pre, logic [11:0] bseq, logic [3:0] wseq);
    logic [2:0] b;
    bit         pot_f, white_f;
    int         outcome, nxt, exp_w;
    check("aim_cue", cue_en[d], 1);
    check("aim_player", cur[d], m_player[d]);
    check_counters(d);
    shot_made[d] = 1'b1;
    balls[d]     = pre;
    m_mask[d]    = m_mask[d] | pre;
    if (m_shots[d] < 255) m_shots[d]++;
    @(negedge clk);
    shot_made[d] = 1'b0;
    balls[d]     = '0;
    check("moving_cue", cue_en[d], 0);
    pot_f   = 1'b0;
    white_f = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      b            = bseq[c*3 +: 3];
      balls[d]     = b;
      white[d]     = wseq[c];
      stopped[d]   = (c == ncyc - 1);
      shot_made[d] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 3; i++) begin
        if (b[i] && !m_mask[d][i]) begin
          m_pots[d][m_player[d]]++;
          pot_f = 1'b1;
        end
      end
      m_mask[d] = m_mask[d] | b;
      if (wseq[c]) white_f = 1'b1;
      @(negedge clk);
    end
    balls[d]     = '0;
    white[d]     = 1'b0;
    stopped[d]   = 1'b0;
    shot_made[d] = 1'b0;

    check("resolve_rcue", rcue[d], 1);
    check("resolve_cue", cue_en[d], 0);
    check_counters(d);

    nxt   = (m_player[d] + 1) % 2;
    exp_w = 0;
    if (m_mask[d][2]) begin
      if (white_f || m_mask[d][1:0] != 2'b11) begin
        outcome = O_LOSE;
        exp_w   = nxt;
      end else begin
        outcome = O_WIN;
        exp_w   = m_player[d];
      end
    end else if (white_f) outcome = O_FOUL;
    else if (m_max[d] != 0 && m_shots[d] == m_max[d]) begin
      outcome = O_LOSE;
      exp_w   = (m_pots[d][1] > m_pots[d][0]) ? 1 : 0;
    end else if (pot_f) outcome = O_KEEP;
    else outcome = O_NEXT;

    check("foul", foul[d], outcome == O_FOUL);
    @(negedge clk);
    check("foul_after", foul[d], 0);
    case (outcome)
      O_FOUL: begin
        m_player[d] = nxt;
        check("white_in_rwhite", rwhite[d], 1);
        check("white_in_rcue", rcue[d], 1);
        check("white_in_cue", cue_en[d], 0);
        check("white_in_player", cur[d], m_player[d]);
        check_counters(d);
        @(negedge clk);
        check("after_foul_cue", cue_en[d], 1);
      end
      O_KEEP, O_NEXT: begin
        if (outcome == O_NEXT) m_player[d] = nxt;
        check("turn_cue", cue_en[d], 1);
        check("turn_player", cur[d], m_player[d]);
        check("turn_rcue", rcue[d], 0);
      end
      O_LOSE: begin
        m_done[d] = 1'b1;
        check("lose_over", over[d], 1);
        check("lose_win", win[d], 0);
        check("lose_winner", winner[d], exp_w);
        check("lose_cue", cue_en[d], 0);
      end
      default: begin
        m_done[d] = 1'b1;
        check("win_win", win[d], 1);
        check("win_over", over[d], 0);
        check("win_winner", winner[d], exp_w);
        check("win_cue", cue_en[d], 0);
      end
    endcase
  endtask

  task automatic random_shot(int d);
    int          ncyc;
    logic [11:0] bseq;
    logic [3:0]  wseq;
    logic [2:0]  pre;
    ncyc = $urandom_range(1, 4);
    bseq = '0;
    wseq = '0;
    for (int c = 0; c < ncyc; c++) begin
      if ($urandom_range(0, 4) == 0) bseq[c*3 +: 3] = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) wseq[c] = 1'b1;
    end
    pre = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    do_shot(d, ncyc, pre, bseq, wseq);
  endtask

  initial begin
    m_max[0] = 0;
    m_max[1] = 2;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      new_game[d] = 1'b0; shot_made[d] = 1'b0; stopped[d] = 1'b0;
      white[d] = 1'b0; balls[d] = '0;
      model_clear(d);
    end

    // Reset state, then release into AIM.
    #12;
    for (int d = 0; d < 2; d++) begin
      check("rst_rcue", rcue[d], 1);
      check("rst_rwhite", rwhite[d], 1);
      check("rst_cue", cue_en[d], 0);
      check("rst_foul", foul[d], 0);
      check("rst_over", over[d], 0);
      check("rst_win", win[d], 0);
      check("rst_player", cur[d], 0);
      check_counters(d);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_cue0", cue_en[0], 1);
    check("rel_cue1", cue_en[1], 1);

    // Plain miss passes the turn.
    start_game(0);
    do_shot(0, 2, 3'b000, 12'h000, 4'h0);
    check("plan_miss_player", cur[0], 1);
    check("plan_miss_shots", shots[0], 1);

    // Pot, scratch, miss, then the final ball with ball 1 still on the table.
    start_game(0);
    do_shot(0, 1, 3'b000, 12'b001, 4'h0);
    check("plan_pot_player", cur[0], 0);
    check("plan_pot_mask", mask[0], 3'b001);
    do_shot(0, 2, 3'b000, 12'h000, 4'b0001);
    check("plan_scratch_mask", mask[0], 3'b001);
    do_shot(0, 1, 3'b000, 12'h000, 4'h0);
    do_shot(0, 1, 3'b000, 12'b100, 4'h0);
    check("plan_early_black_winner", winner[0], 1);

    // Clean win, then final ball with the white.
    start_game(0);
    do_shot(0, 1, 3'b000, 12'b011, 4'h0);
    do_shot(0, 1, 3'b000, 12'b100, 4'h0);
    check("plan_clean_win", win[0], 1);
    start_game(0);
    do_shot(0, 1, 3'b000, 12'b011, 4'h0);
    do_shot(0, 1, 3'b000, 12'b100, 4'b0001);
    check("plan_black_white_over", over[0], 1);

    // Shot limit of two with tied pot counts, then a fresh game.
    start_game(1);
    do_shot(1, 1, 3'b000, 12'h000, 4'h0);
    do_shot(1, 2, 3'b000, 12'h000, 4'h0);
    check("plan_limit_winner", winner[1], 0);
    check("plan_limit_shots", shots[1], 2);
    start_game(1);

    // Shot counter saturation.
    start_game(0);
    repeat (257) do_shot(0, 1, 3'b000, 12'h000, 4'h0);
    check("shots_saturated", shots[0], 255);

    // Asynchronous reset in the middle of a shot.
    start_game(0);
    do_shot(0, 1, 3'b000, 12'b001, 4'h0);
    shot_made[0] = 1'b1;
    @(negedge clk);
    shot_made[0] = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_rcue", rcue[0], 1);
    check("midrst_rwhite", rwhite[0], 1);
    check("midrst_cue", cue_en[0], 0);
    check("midrst_shots", shots[0], 0);
    check("midrst_mask", mask[0], 0);
    check("midrst_pots", pots[0], 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear(0);
    model_clear(1);
    @(negedge clk);
    check("midrst_aim0", cue_en[0], 1);
    check("midrst_aim1", cue_en[1], 1);

    // Randomised games on both instances.
    for (int g = 0; g < 30; g++) begin
      int d;
      d = g % 2;
      start_game(d);
      for (int s = 0; s < 40 && !m_done[d]; s++) random_shot(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pool_rules_engine.md
# pool_rules_engine

Parametrised rules engine for the pool game: tracks turns for `NUM_PLAYERS` players over `NUM_BALLS` object balls, counts shots, credits pots per player, and handles fouls and white-ball re-spot. It decides win/loss, where the highest-index ball is the final ("black") ball. It sits between the physics/collision blocks, which supply the pocket pulses and the stop indication, and the cue, white-ball and display logic, which consume its enables, re-spot pulses and counters.

## Interface
- `NUM_BALLS`, 3: number of object balls (≥2). Index `NUM_BALLS-1` is the final ball.
- `NUM_PLAYERS`, 2: number of players (≥1). `PW = max(1, $clog2(NUM_PLAYERS))`.
- `SHOT_W`, 8: shot counter width.
- `MAX_SHOTS`, 0: shot limit. 0 means unlimited; otherwise it must be ≤ 2^SHOT_W−1.
- `CNT_W`, derived: `$clog2(NUM_BALLS+1)`, the per-player pot counter width.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `new_game`, in, 1: one-cycle pulse. Restarts the game from any state.
- `shot_made`, in, 1: one-cycle pulse when the cue strikes.
- `all_balls_stopped`, in, 1: level, high when all motion has ceased.
- `white_in_hole`, in, 1: one-cycle pulse when the cue ball is pocketed.
- `ball_in_hole`, in, NUM_BALLS: per-ball one-cycle pocket pulses.
- `cue_enable`, out, 1: cue may be aimed/shot.
- `reset_cue`, out, 1: active-high request to re-home the cue.
- `reset_white_ball`, out, 1: active-high request to re-spot the white ball.
- `foul`, out, 1: one-cycle pulse on a white-ball scratch.
- `game_over`, out, 1: current player lost, or shot limit reached.
- `game_win`, out, 1: game won.
- `current_player`, out, PW: the player whose turn it is.
- `winner`, out, PW: valid while `game_over` or `game_win` is high.
- `scored_mask`, out, NUM_BALLS: sticky set of pocketed balls.
- `shots_counter`, out, SHOT_W: total shots taken, saturating.
- `player_pots`, out, NUM_PLAYERS*CNT_W: pot counts, with player p in bits [p*CNT_W +: CNT_W].

## Operation
- State machine states: IDLE, AIM, MOVING, RESOLVE, WHITE_IN, LOSE, WIN.
- IDLE: asserts `reset_cue` and `reset_white_ball`. Always moves to AIM after one cycle.
- AIM: `cue_enable`=1. On `shot_made`:
  - `shots_counter` increments, saturating at 2^SHOT_W−1.
  - Per-shot flags `pot_this_shot` and `white_this_shot` clear.
  - State moves to MOVING.
- `shot_made` in any state other than AIM is ignored.
- MOVING: `cue_enable`=0.
  - `ball_in_hole[i]` sets `scored_mask[i]`.
  - If that bit was previously clear, the pulse also sets `pot_this_shot` and increments the current player's pot count.
  - `white_in_hole` sets `white_this_shot`.
  - When `all_balls_stopped`=1, state moves to RESOLVE.
  - Pulses arriving in the same cycle as the stop indication are still recorded.
- Pocket pulses outside MOVING still set `scored_mask` but credit no player and set no per-shot flag.
- RESOLVE lasts one cycle, asserts `reset_cue`, and applies the rules in this priority order:
  1. If `scored_mask[NUM_BALLS-1]` is set:
     - If `white_this_shot` is set, or any lower ball is unscored, go to LOSE with `winner` = the next player.
     - Otherwise go to WIN with `winner` = `current_player`.
  2. Else if `white_this_shot` is set: pulse `foul`, advance to the next player, go to WHITE_IN.
  3. Else if `MAX_SHOTS`≠0 and `shots_counter`==`MAX_SHOTS`: go to LOSE with `winner` = the player with the highest pot count (lowest index on ties).
  4. Else if `pot_this_shot` is set: go to AIM with the same player.
  5. Else: advance to the next player and go to AIM.
- Next player is `(current_player+1)`, wrapping from NUM_PLAYERS−1 to 0. With NUM_PLAYERS=1 the player stays 0.
- WHITE_IN: asserts `reset_white_ball` and `reset_cue` for one cycle, then moves to AIM.
- LOSE drives `game_over`=1. WIN drives `game_win`=1. Both are terminal and hold `cue_enable`=0.
- `new_game` in any state:
  - Clears all counters, `scored_mask`, per-shot flags and `current_player`.
  - Moves to IDLE.
  - Takes priority over every other transition in that cycle.

## Timing
- On `reset` assertion, asynchronously:
  - State goes to IDLE.
  - All counters, masks, `current_player`, `winner` and per-shot flags go to 0.
  - Outputs then read: `cue_enable`=0, `reset_cue`=1, `reset_white_ball`=1, `foul`=0, `game_over`=0, `game_win`=0.
- Reset mid-game behaves identically: there is no retained state.
- All flag outputs are decoded from the registered state only (Moore); there is no input-to-output combinational path.
- `foul` is high exactly during the RESOLVE cycle that selects WHITE_IN.
- Latencies:
  - `shot_made` to `cue_enable` low: 1 cycle.
  - `all_balls_stopped` to RESOLVE: 1 cycle.
  - RESOLVE to AIM: 1 cycle on the normal path, 2 cycles via WHITE_IN.
  - RESOLVE to `game_over`/`game_win` high: 1 cycle.
- `current_player` updates on the clock edge leaving RESOLVE.
- Counter updates are visible the cycle after the triggering pulse.

## Test plan
All scenarios use NUM_BALLS=3 and NUM_PLAYERS=2.

- Reset, then release: IDLE for 1 cycle; `reset_cue` and `reset_white_ball` are high during IDLE; then AIM with `cue_enable`=1, `current_player`=0, `shots_counter`=0.
- Shot with no pot, then stop: `shots_counter`=1; after RESOLVE, `current_player`=1.
- Shot pots ball 0, then stop: `current_player` stays 0; `scored_mask`=3'b001; player 0 pot count = 1.
- Scratch (`white_in_hole` during MOVING): `foul` pulses once; WHITE_IN for 1 cycle with `reset_white_ball`=1; `current_player` advances; `scored_mask` is unchanged.
- Endgame:
  - Pot ball 2 while ball 1 is unscored: `game_over`=1, `winner`=1.
  - Separate run, pot balls 0 and 1, then ball 2 cleanly: `game_win`=1, `winner`=shooter.
  - Ball 2 and white on the same shot: `game_over`=1.
- MAX_SHOTS=2, two shots with no pots, then `new_game` in LOSE:
  - Before `new_game`: `game_over`=1, `winner`=0 (pot counts tied), `shots_counter`=2.
  - After `new_game`: IDLE, then AIM with all counters 0.
